key_filter_multi: RTL

Multi-channel push-button conditioner, successor to the single-key debouncer. Each of `KEY_NUM` active-low mechanical inputs is synchronised, debounced with a per-channel counter, and reported as a clean level plus one-cycle press and release pulses. An optional long-press detector per channel is available. The block sits between board key pins and the control logic, such as menu FSMs and LED/segment drivers, in the 50 MHz `sys_clk` domain.

---
 rtl/key_filter_multi.sv | 134 +++++++++++++
 1 files changed

// File: rtl/key_filter_multi.sv
// Multi-channel active-low key conditioner: 2FF sync, per-channel debounce, press/release pulses.
// Define KEY_LONG_EN to add a per-channel one-shot long-press pulse on key_long.

module key_filter_lane #(
  parameter logic [19:0] CNT_MAX  = 20'd999_999,
  parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_flag,
  output logic key_release,
  output logic key_long
);
  localparam int CW = $bits(CNT_MAX);
  localparam int LW = $bits(LONG_MAX);

  logic [1:0]    sync_r;
  logic          sync;
  logic          stab, stab_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          fire;
  logic          flag_nxt, rel_nxt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sync_r <= 2'b11;
    else            sync_r <= {sync_r[0], key_in};
  end
  assign sync = sync_r[1];

  // stab/cnt encode IDLE, PRESS_PEND, HELD, REL_PEND
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stab <= 1'b1;
      cnt  <= '0;
    end else begin
      stab <= stab_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // any sample equal to stab restarts the window
  always_comb begin
    stab_nxt = stab;
    cnt_nxt  = '0;
    fire     = 1'b0;
    if (sync != stab) begin
      if (cnt == CNT_MAX) begin
        stab_nxt = sync;
        fire     = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_comb begin
    flag_nxt = fire & ~sync;
    rel_nxt  = fire &  sync;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_state   <= 1'b0;
      key_flag    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_state   <= ~stab_nxt;
      key_flag    <= flag_nxt;
      key_release <= rel_nxt;
    end
  end

`ifdef KEY_LONG_EN
  logic [LW-1:0] lcnt;
  logic          ldone;

  // lcnt saturates at LONG_MAX; ldone makes the pulse one-shot per press
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lcnt     <= '0;
      ldone    <= 1'b0;
      key_long <= 1'b0;
    end else if (stab || rel_nxt) begin
      lcnt     <= '0;
      ldone    <= 1'b0;
      key_long <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (lcnt != LONG_MAX) begin
        lcnt <= lcnt + LW'(1);
      end else if (!ldone) begin
        key_long <= 1'b1;
        ldone    <= 1'b1;
      end
    end
  end
`else
  logic [LW-1:0] unused_long;
  assign unused_long = LONG_MAX;
  assign key_long    = 1'b0;
`endif

endmodule

module key_filter_multi #(
  parameter int          KEY_NUM  = 4,
  parameter logic [19:0] CNT_MAX  = 20'd999_999,
  parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  key_filter_lane #(
    .CNT_MAX  (CNT_MAX),
    .LONG_MAX (LONG_MAX)
  ) u_lane [KEY_NUM-1:0] (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_flag    (key_flag),
    .key_release (key_release),
    .key_long    (key_long)
  );

endmodule
